mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 SHALL provide parameter MODULUS, default 16, count range 0..MODULUS-1 (2..2^WIDTH).
REQ-003 SHALL provide parameter PRESCALE, default 1, enabled cycles per count step (1..256).
REQ-004 SHALL provide port CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL provide port RST_N  input  1  reset, synchronous, active-low.
REQ-006 SHALL provide port EN  input  1  count enable, advances prescaler.
REQ-007 SHALL provide port UP  input  1  direction: 1 increment, 0 decrement.
REQ-008 SHALL provide port LOAD  input  1  synchronous load of D.
REQ-009 SHALL provide port D  input  WIDTH  load value.
REQ-010 SHALL provide port CLR  input  1  clears OVF.
REQ-011 SHALL provide port Q  output  WIDTH  registered count value.
REQ-012 SHALL provide port TC  output  1  registered terminal-count pulse.
REQ-013 SHALL provide port OVF  output  1  sticky boundary-crossing flag.

Function
REQ-014 Priority SHALL be RST_N low > LOAD > count step; CLR is independent of this priority.
REQ-015 LOAD SHALL set Q to D next cycle; D >= MODULUS SHALL load MODULUS-1; LOAD SHALL zero the prescaler and suppress any step that cycle.
REQ-016 Prescaler SHALL count 0..PRESCALE-1 on EN-high cycles; step SHALL occur on the EN-high cycle where prescaler = PRESCALE-1, prescaler then returns to 0.
REQ-017 EN low SHALL hold Q and prescaler; UP change mid-prescale SHALL NOT reset prescaler.
REQ-018 PRESCALE = 1 SHALL step on every EN-high cycle (no prescaler latency).
REQ-019 Step with UP=1 SHALL give Q+1, Q = MODULUS-1 wraps to 0; UP=0 SHALL give Q-1, Q = 0 wraps to MODULUS-1.
REQ-020 TC SHALL be high exactly one cycle, the cycle after a step taken at the bound (MODULUS-1 going up, 0 going down); otherwise low.
REQ-021 OVF SHALL set on any cycle TC would assert and stay set until CLR; simultaneous set and CLR SHALL leave OVF = 1.
REQ-022 Arithmetic SHALL be modulo MODULUS; Q SHALL never hold a value >= MODULUS.
REQ-023 Q update latency from qualifying edge SHALL be one cycle.

Reset
REQ-024 RST_N low at a rising CLK edge SHALL set Q = 0, TC = 0, OVF = 0, prescaler = 0.
REQ-025 Reset SHALL override LOAD, EN, CLR that cycle; reset mid-prescale SHALL discard partial prescale.
REQ-026 Outputs SHALL be undefined only before the first reset edge; no asynchronous path from RST_N.

Configuration
REQ-027 Macro MOD_COUNTER_SAT_EN defined SHALL add port SAT input 1; SAT=1 SHALL hold Q at the bound instead of wrapping, still pulsing TC and setting OVF.
REQ-028 Macro MOD_COUNTER_SAT_EN undefined SHALL omit SAT; counter SHALL always wrap per REQ-019.

Verification (WIDTH=4, MODULUS=10, PRESCALE=3 unless noted)
REQ-029 Reset then EN=1 UP=1 for 30 cycles -> Q steps every 3rd cycle 0..9, returns to 0 after cycle 30; TC one cycle after wrap; OVF=1.
REQ-030 LOAD D=7 then EN=1 UP=0, 24 cycles -> Q 7,6..0,9; TC once after 0->9; LOAD D=12 -> Q=9.
REQ-031 PRESCALE=1, EN toggling 1/0 for 8 cycles -> Q increments only on EN-high cycles, 0->4.
REQ-032 OVF=1, CLR=1 coincident with wrap step -> OVF stays 1; CLR next cycle alone -> OVF=0.
REQ-033 RST_N low while prescaler=2 and LOAD=1 D=5 -> Q=0, TC=0, OVF=0; next step needs full 3 EN cycles.
REQ-034 MOD_COUNTER_SAT_EN defined, SAT=1, Q=9, UP=1, 6 EN cycles -> Q stays 9, TC pulses twice, OVF=1.

Source files
------------

// File: rtl/mod_counter.sv
// ============================================================================
// mod_counter : prescaled up/down modulo-N counter with load, TC pulse, sticky OVF
// Optional MOD_COUNTER_SAT_EN adds SAT input (hold at bound instead of wrap)
// Revision 1.0
// ============================================================================
`default_nettype none

module mod_counter #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter int              PRESCALE = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             CLR,
`ifdef MOD_COUNTER_SAT_EN
    input  logic             SAT,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    localparam int               c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] c_MAX     = WIDTH'(MODULUS - 64'd1);
    localparam logic [c_PW-1:0]  c_PRE_MAX = c_PW'(PRESCALE - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [c_PW-1:0]  pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic             step;
    logic             at_bound;
    logic             sat_w;

`ifdef MOD_COUNTER_SAT_EN
    assign sat_w = SAT;
`else
    assign sat_w = 1'b0;
`endif

    // With PRESCALE=1 the prescaler is pinned at 0 == c_PRE_MAX, so every EN cycle steps.
    assign step     = EN && !LOAD && (pre_q == c_PRE_MAX);
    assign at_bound = UP ? (count_q == c_MAX) : (count_q == '0);

    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        if (LOAD) begin
            pre_d   = '0;
            count_d = (D > c_MAX) ? c_MAX : D;
        end else begin
            if (EN) begin
                pre_d = (pre_q == c_PRE_MAX) ? '0 : pre_q + c_PW'(1);
            end
            if (step) begin
                if (at_bound) begin
                    if (!sat_w) begin
                        count_d = UP ? '0 : c_MAX;
                    end
                end else begin
                    count_d = UP ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                end
            end
        end
        tc_d  = step && at_bound;
        // A new overflow event beats a coincident clear.
        ovf_d = tc_d || (ovf_q && !CLR);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Q   = count_q;
    assign TC  = tc_q;
    assign OVF = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// ============================================================================
// tb_mod_counter : directed self-checking bench (MODULUS=10, PRESCALE=3 and 1)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mod_counter;

    logic       CLK = 1'b0;
    logic       RST_N, EN, UP, LOAD, CLR;
    logic [3:0] D;
`ifdef MOD_COUNTER_SAT_EN
    logic       SAT;
`endif
    logic [3:0] qa, qb;
    logic       tca, tcb, ovfa, ovfb;

    int n_total = 0;
    int n_bad   = 0;

    always #5 CLK = ~CLK;

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D), .CLR(CLR),
`ifdef MOD_COUNTER_SAT_EN
        .SAT(SAT),
`endif
        .Q(qa), .TC(tca), .OVF(ovfa)
    );

    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .UP(UP), .LOAD(LOAD), .D(D), .CLR(CLR),
`ifdef MOD_COUNTER_SAT_EN
        .SAT(SAT),
`endif
        .Q(qb), .TC(tcb), .OVF(ovfb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int exp_q;
        int tc_cnt;

        RST_N = 1'b0; EN = 1'b0; UP = 1'b0; LOAD = 1'b0; CLR = 1'b0; D = 4'd0;
`ifdef MOD_COUNTER_SAT_EN
        SAT = 1'b0;
`endif
        tick(); tick();
        chk("rst_q", qa, 0);
        chk("rst_tc", tca, 0);
        chk("rst_ovf", ovfa, 0);
        chk("rst_qb", qb, 0);

        // Count up, one step every third enabled cycle, wrap at 9 -> 0
        RST_N = 1'b1; EN = 1'b1; UP = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk($sformatf("up_q[%0d]", i), qa, (i / 3) % 10);
            chk($sformatf("up_tc[%0d]", i), tca, (i == 30) ? 1 : 0);
            chk($sformatf("up_ovf[%0d]", i), ovfa, (i == 30) ? 1 : 0);
        end
        EN = 1'b0;
        tick();
        chk("up_tc_after", tca, 0);
        chk("up_ovf_sticky", ovfa, 1);
        chk("up_hold_q", qa, 0);

        // Load 7 then count down through 0 -> 9
        LOAD = 1'b1; D = 4'd7; EN = 1'b1; UP = 1'b0;
        tick();
        chk("ld7_q", qa, 7);
        chk("ld7_tc", tca, 0);
        LOAD = 1'b0;
        for (int j = 1; j <= 24; j++) begin
            tick();
            exp_q = (j / 3 <= 7) ? 7 - (j / 3) : 9;
            chk($sformatf("dn_q[%0d]", j), qa, exp_q);
            chk($sformatf("dn_tc[%0d]", j), tca, (j == 24) ? 1 : 0);
        end
        EN = 1'b0; LOAD = 1'b1; D = 4'd12;
        tick();
        chk("ld12_q", qa, 9);
        D = 4'd15;
        tick();
        chk("ld15_q", qa, 9);
        D = 4'd9;
        tick();
        chk("ld9_q", qa, 9);
        D = 4'd0;
        tick();
        chk("ld0_q", qa, 0);

        // CLR coincident with a wrap step: set wins; CLR alone then clears
        LOAD = 1'b0; EN = 1'b1; UP = 1'b0;
        tick(); tick();
        CLR = 1'b1;
        tick();
        chk("clr_co_q", qa, 9);
        chk("clr_co_tc", tca, 1);
        chk("clr_co_ovf", ovfa, 1);
        EN = 1'b0;
        tick();
        chk("clr_only_ovf", ovfa, 0);
        chk("clr_only_tc", tca, 0);
        CLR = 1'b0;

        // EN low holds prescaler; direction change mid-prescale keeps its progress
        EN = 1'b1; tick();
        EN = 1'b0; tick(); tick();
        UP = 1'b1; EN = 1'b1; tick();
        chk("hold_q", qa, 9);
        tick();
        chk("hold_step_q", qa, 0);
        chk("hold_step_tc", tca, 1);
        chk("hold_step_ovf", ovfa, 1);

        // Reset mid-prescale overrides LOAD and discards partial prescale
        tick(); tick();
        RST_N = 1'b0; LOAD = 1'b1; D = 4'd5;
        tick();
        chk("rst2_q", qa, 0);
        chk("rst2_tc", tca, 0);
        chk("rst2_ovf", ovfa, 0);
        RST_N = 1'b1; LOAD = 1'b0;
        tick(); chk("rst2_p1", qa, 0);
        tick(); chk("rst2_p2", qa, 0);
        tick(); chk("rst2_p3", qa, 1);

        // PRESCALE=1 instance steps on every EN-high cycle only
        EN = 1'b0; RST_N = 1'b0;
        tick();
        RST_N = 1'b1; UP = 1'b1;
        for (int k = 0; k < 8; k++) begin
            EN = (k % 2 == 0);
            tick();
            chk($sformatf("ps1_q[%0d]", k), qb, (k / 2) + 1);
        end
        chk("ps1_final", qb, 4);

`ifdef MOD_COUNTER_SAT_EN
        // Saturating mode: hold at 9, TC still pulses per bound step
        EN = 1'b0; RST_N = 1'b0;
        tick();
        RST_N = 1'b1; LOAD = 1'b1; D = 4'd9;
        tick();
        LOAD = 1'b0; SAT = 1'b1; UP = 1'b1; EN = 1'b1;
        tc_cnt = 0;
        for (int m = 0; m < 6; m++) begin
            tick();
            if (tca) tc_cnt++;
            chk($sformatf("sat_q[%0d]", m), qa, 9);
        end
        EN = 1'b0;
        tick();
        if (tca) tc_cnt++;
        chk("sat_tc_count", tc_cnt, 2);
        chk("sat_ovf", ovfa, 1);
        SAT = 1'b0;
`else
        tc_cnt = 0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
